// File: rtl/rip_branch_tracker.sv
// rip_branch_tracker
//
// In-order tracker for in-flight conditional branches. Each predicted branch
// is captured at fetch as {PHT index, 2-bit counter weight, predicted
// direction}. At resolve, the oldest entry is popped and the predictor
// training port is driven with registered outputs. A misprediction also
// raises a one-cycle mispredict pulse and discards every younger
// (wrong-path) entry.
//
// Ports
//   clk_i             clock; all state changes on the rising edge
//   rstn_i            synchronous active-low reset
//   push_valid_i      fetch presents a predicted branch
//   push_ready_o      an entry is free (count < DEPTH); driven from registered count only
//   push_index_i      predictor PHT index
//   push_weight_i     predictor 2-bit counter weight
//   push_pred_i       predicted direction (1 = taken)
//   resolve_valid_i   execute resolves the oldest tracked branch
//   resolve_actual_i  actual direction (1 = taken)
//   flush_i           discard all entries without training
//   update_o          predictor write enable (one cycle per resolve)
//   update_index_o    PHT index to train; holds while update_o = 0
//   update_weight_o   weight captured at prediction time; holds while update_o = 0
//   actual_o          resolved direction; holds while update_o = 0
//   mispredict_o      resolved direction differs from prediction (one cycle)
//   count_o           number of occupied entries

module rip_branch_tracker #(
  parameter int unsigned INDEX_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [INDEX_WIDTH-1:0] push_index_i,
  input  logic [1:0]             push_weight_i,
  input  logic                   push_pred_i,
  input  logic                   resolve_valid_i,
  input  logic                   resolve_actual_i,
  input  logic                   flush_i,
  output logic                   update_o,
  output logic [INDEX_WIDTH-1:0] update_index_o,
  output logic [1:0]             update_weight_o,
  output logic                   actual_o,
  output logic                   mispredict_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage. Not reset: an entry is only read while count_q says it is
  // occupied, and every occupied slot was written by an accepted push.
  logic [INDEX_WIDTH-1:0] index_q [DEPTH];
  logic [1:0]             weight_q[DEPTH];
  logic                   pred_q  [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic                   update_q, update_d;
  logic                   mispredict_q, mispredict_d;
  logic [INDEX_WIDTH-1:0] update_index_q, update_index_d;
  logic [1:0]             update_weight_q, update_weight_d;
  logic                   actual_q, actual_d;

  logic push_accept;
  logic push_write;
  logic resolve_eff;
  logic head_pred;
  logic mispredict;
  logic squash;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------

  // Ready looks only at the registered occupancy, so a full tracker refuses a
  // push even in a cycle where the head is popped.
  assign push_ready_o = (count_q < CntW'(DEPTH));
  assign push_accept  = push_valid_i && push_ready_o;
  assign resolve_eff  = resolve_valid_i && (count_q != '0);
  assign head_pred    = pred_q[head_q];
  assign mispredict   = resolve_eff && (head_pred ^ resolve_actual_i);

  // Anything younger than a mispredicting branch, or anything present at a
  // flush, is wrong-path work; that includes a push arriving this cycle.
  assign squash     = flush_i || mispredict;
  assign push_write = push_accept && !squash;

  // ---------------------------------------------------------------------------
  // Pointer / occupancy next state
  // ---------------------------------------------------------------------------

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (resolve_eff) begin
      head_d = head_q + PtrW'(1);
    end

    if (squash) begin
      // The popped head (if any) has already left; drop everything behind it.
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (push_write) begin
        tail_d = tail_q + PtrW'(1);
      end
      unique case ({push_write, resolve_eff})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Training-port next state
  // ---------------------------------------------------------------------------

  always_comb begin
    update_d        = resolve_eff;
    mispredict_d    = mispredict;
    update_index_d  = update_index_q;
    update_weight_d = update_weight_q;
    actual_d        = actual_q;

    if (resolve_eff) begin
      update_index_d  = index_q[head_q];
      update_weight_d = weight_q[head_q];
      actual_d        = resolve_actual_i;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      update_q        <= 1'b0;
      mispredict_q    <= 1'b0;
      update_index_q  <= '0;
      update_weight_q <= '0;
      actual_q        <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      update_q        <= update_d;
      mispredict_q    <= mispredict_d;
      update_index_q  <= update_index_d;
      update_weight_q <= update_weight_d;
      actual_q        <= actual_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_write) begin
      index_q[tail_q]  <= push_index_i;
      weight_q[tail_q] <= push_weight_i;
      pred_q[tail_q]   <= push_pred_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign update_o        = update_q;
  assign mispredict_o    = mispredict_q;
  assign update_index_o  = update_index_q;
  assign update_weight_o = update_weight_q;
  assign actual_o        = actual_q;
  assign count_o         = count_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------

  // Occupancy never exceeds capacity.
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_q <= CntW'(DEPTH));

  // Tail always sits count entries ahead of head (modulo DEPTH).
  a_ptr_consistent: assert property (@(posedge clk_i) disable iff (!rstn_i)
    tail_q == PtrW'(head_q + count_q[PtrW-1:0]));

  // A training pulse is never emitted without a mispredict qualifier being
  // meaningful: mispredict implies update.
  a_mis_implies_update: assert property (@(posedge clk_i) disable iff (!rstn_i)
    mispredict_q |-> update_q);

endmodule

// File: tb/tb_rip_branch_tracker.sv
// Self-checking bench for rip_branch_tracker: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_rip_branch_tracker;

  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  localparam logic [1:0] STRONGLY_UNTAKEN = 2'b00;
  localparam logic [1:0] WEAKLY_UNTAKEN   = 2'b01;
  localparam logic [1:0] WEAKLY_TAKEN     = 2'b10;
  localparam logic [1:0] STRONGLY_TAKEN   = 2'b11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          push_valid;
  logic          push_ready;
  logic [IW-1:0] push_index;
  logic [1:0]    push_weight;
  logic          push_pred;
  logic          resolve_valid;
  logic          resolve_actual;
  logic          flush;
  logic          update;
  logic [IW-1:0] update_index;
  logic [1:0]    update_weight;
  logic          actual;
  logic          mispredict;
  logic [2:0]    count;

  always #5 clk = ~clk;

  rip_branch_tracker #(
    .INDEX_WIDTH(IW),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .push_valid_i    (push_valid),
    .push_ready_o    (push_ready),
    .push_index_i    (push_index),
    .push_weight_i   (push_weight),
    .push_pred_i     (push_pred),
    .resolve_valid_i (resolve_valid),
    .resolve_actual_i(resolve_actual),
    .flush_i         (flush),
    .update_o        (update),
    .update_index_o  (update_index),
    .update_weight_o (update_weight),
    .actual_o        (actual),
    .mispredict_o    (mispredict),
    .count_o         (count)
  );

  // Reference model: the tracker is just an ordered list of in-flight branches.
  typedef struct {
    logic [IW-1:0] idx;
    logic [1:0]    wt;
    logic          pred;
  } ent_t;

  ent_t          q[$];
  logic          m_update, m_mis, m_act;
  logic [IW-1:0] m_idx;
  logic [1:0]    m_wt;
  bit            known = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, advance the model, check #1 after posedge.
  task automatic step(input logic rn, input logic pv, input logic [IW-1:0] pidx,
                      input logic [1:0] pw, input logic pp, input logic rv,
                      input logic ra, input logic fl);
    bit   ready;
    ent_t e;
    @(negedge clk);
    rstn           = rn;
    push_valid     = pv;
    push_index     = pidx;
    push_weight    = pw;
    push_pred      = pp;
    resolve_valid  = rv;
    resolve_actual = ra;
    flush          = fl;
    ready = (q.size() < DEPTH);
    if (known) check("push_ready", 64'(push_ready), 64'(ready));

    if (!rn) begin
      q.delete();
      m_update = 1'b0;
      m_mis    = 1'b0;
      m_idx    = '0;
      m_wt     = '0;
      m_act    = 1'b0;
    end else begin
      m_update = 1'b0;
      m_mis    = 1'b0;
      if (rv && q.size() != 0) begin
        e        = q.pop_front();
        m_update = 1'b1;
        m_idx    = e.idx;
        m_wt     = e.wt;
        m_act    = ra;
        m_mis    = (e.pred != ra);
      end
      if (fl || m_mis) q.delete();
      else if (pv && ready) q.push_back('{idx: pidx, wt: pw, pred: pp});
    end

    @(posedge clk);
    #1;
    if (!rn) known = 1'b1;
    if (known) begin
      check("update",     64'(update),     64'(m_update));
      check("mispredict", 64'(mispredict), 64'(m_mis));
      check("upd_index",  64'(update_index), 64'(m_idx));
      check("upd_weight", 64'(update_weight), 64'(m_wt));
      check("actual",     64'(actual),     64'(m_act));
      check("count",      64'(count),      64'(q.size()));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic push(input logic [IW-1:0] idx, input logic [1:0] w, input logic p);
    step(1'b1, 1'b1, idx, w, p, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic resolve(input logic a);
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b1, a, 1'b0);
  endtask
  task automatic idle();
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; push_valid = 1'b0; push_index = '0; push_weight = '0; push_pred = 1'b0;
    resolve_valid = 1'b0; resolve_actual = 1'b0; flush = 1'b0;

    // Reset + empty resolve.
    do_reset();
    do_reset();
    check("rst_ready", 64'(push_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    resolve(1'b1);
    check("empty_res_update", 64'(update), 64'd0);

    // In-order training.
    push(32'h10, WEAKLY_TAKEN, 1'b1);
    push(32'h20, STRONGLY_UNTAKEN, 1'b0);
    resolve(1'b1);
    check("io_idx0", 64'(update_index), 64'h10);
    check("io_wt0",  64'(update_weight), 64'(WEAKLY_TAKEN));
    resolve(1'b0);
    check("io_idx1", 64'(update_index), 64'h20);
    check("io_upd1", 64'(update), 64'd1);
    check("io_cnt",  64'(count), 64'd0);

    // Mispredict squash with same-cycle push.
    push(32'h31, STRONGLY_TAKEN, 1'b1);
    push(32'h32, WEAKLY_UNTAKEN, 1'b0);
    push(32'h33, WEAKLY_TAKEN, 1'b1);
    step(1'b1, 1'b1, 32'h34, WEAKLY_TAKEN, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sq_mis", 64'(mispredict), 64'd1);
    check("sq_idx", 64'(update_index), 64'h31);
    check("sq_cnt", 64'(count), 64'd0);
    push(32'h99, WEAKLY_UNTAKEN, 1'b0);
    resolve(1'b0);
    check("sq_new_idx", 64'(update_index), 64'h99);

    // Full backpressure: count 4, 3, 4.
    for (int i = 0; i < 4; i++) push(32'h40 + IW'(i), WEAKLY_TAKEN, 1'b1);
    check("full_cnt", 64'(count), 64'd4);
    step(1'b1, 1'b1, 32'h44, WEAKLY_TAKEN, 1'b1, 1'b1, 1'b1, 1'b0);
    check("bp_cnt3", 64'(count), 64'd3);
    push(32'h44, WEAKLY_TAKEN, 1'b1);
    check("bp_cnt4", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) resolve(1'b1);

    // Wrap-around.
    for (int i = 0; i < 10; i++) begin
      push(32'h100 + IW'(i), 2'(i), 1'b1);
      resolve(1'b1);
      check("wrap_idx", 64'(update_index), 64'(32'h100 + i));
    end

    // Flush + resolve in the same cycle.
    push(32'h51, STRONGLY_UNTAKEN, 1'b0);
    push(32'h52, WEAKLY_TAKEN, 1'b1);
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    check("fl_upd", 64'(update), 64'd1);
    check("fl_idx", 64'(update_index), 64'h51);
    check("fl_mis", 64'(mispredict), 64'd0);
    check("fl_cnt", 64'(count), 64'd0);

    // Randomized traffic, occasionally reset mid-operation.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 6),
           IW'($urandom()),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
